// File: rtl/snake_pkg.sv
// Shared grid constants, FSM states and helpers for the snake video path.
// Optional build macro SNAKE_SELF_COLLIDE_EN is consumed by snake_tile_painter.
package snake_pkg;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int CELL_PX = 20;
  localparam int NUM_LEN = 10;
  localparam int MAX_LEN = 16;

  localparam logic [NUM_LEN-1:0] POS_INVALID = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    CLEAR,
    PAINT,
    DONE
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  function automatic logic pos_valid(
    input logic [NUM_LEN-1:0] p
  );
    return p[9:5] < 5'(GRID_H);
  endfunction

endpackage

// File: rtl/snake_pix_to_cell.sv
// Pixel coordinate to grid cell mapping, shared with the food renderer.
// Purely combinational; cells outside 640x480 are flagged by in_range.
module snake_pix_to_cell
  import snake_pkg::*;
(
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [4:0] cell_col,
  output logic [4:0] cell_row,
  output logic       in_range
);

  assign cell_col = 5'(pix_x / 10'(CELL_PX));
  assign cell_row = 5'(pix_y / 10'(CELL_PX));
  assign in_range = (pix_x < 10'(GRID_W * CELL_PX))
                 && (pix_y < 10'(GRID_H * CELL_PX));

endmodule

// File: rtl/snake_tile_painter.sv
// Rebuilds a 32x24 occupancy map from the snake position list each frame.
// Define SNAKE_SELF_COLLIDE_EN to enable duplicate-cell (self-collision) detection.
module snake_tile_painter
  import snake_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [3:0]                 len,
  input  logic [MAX_LEN*NUM_LEN-1:0] pos_num,
  input  logic [9:0]                 pix_x,
  input  logic [9:0]                 pix_y,
  output logic                       busy,
  output logic                       ready,
  output logic                       occupied,
  output logic                       is_head,
  output logic                       collide
);

  state_t state, state_nx;

  logic [NUM_LEN-1:0] seg_q [MAX_LEN];
  logic [GRID_W-1:0]  map   [GRID_H];
  logic [3:0]         len_q;
  logic [3:0]         seg_cnt;
  logic [4:0]         row_cnt;
  logic [NUM_LEN-1:0] seg;
  logic [NUM_LEN-1:0] head;
  logic               head_ok;
  logic [4:0]         cell_col;
  logic [4:0]         cell_row;
  logic               in_range;
  logic               query_en;

  snake_pix_to_cell u_pix_to_cell (
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .cell_col (cell_col),
    .cell_row (cell_row),
    .in_range (in_range)
  );

  assign head    = seg_q[0];
  assign seg     = seg_q[seg_cnt];
  assign head_ok = (len_q != 4'd0) && pos_valid(head);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (frame_start) begin
      state_nx = SNAP;
    end else begin
      unique case (state)
        IDLE:  state_nx = IDLE;
        SNAP:  state_nx = CLEAR;
        CLEAR: if (row_cnt == 5'(GRID_H - 1))
                 state_nx = (len_q == 4'd0) ? DONE : PAINT;
        PAINT: if (seg_cnt == len_q - 4'd1)
                 state_nx = DONE;
        DONE:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= POS_INVALID;
      for (int r = 0; r < GRID_H; r++) map[r] <= '0;
      len_q   <= '0;
      seg_cnt <= '0;
      row_cnt <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else if (frame_start) begin
      // a new frame_start aborts any rebuild in flight
      for (int i = 0; i < MAX_LEN; i++)
        seg_q[i] <= pos_num[i*NUM_LEN +: NUM_LEN];
      len_q   <= len;
      seg_cnt <= '0;
      row_cnt <= '0;
      busy    <= 1'b1;
      ready   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          map[row_cnt] <= '0;
          if (row_cnt != 5'(GRID_H - 1)) row_cnt <= row_cnt + 5'd1;
        end
        PAINT: begin
          if (pos_valid(seg)) map[seg[9:5]][seg[4:0]] <= 1'b1;
          seg_cnt <= seg_cnt + 4'd1;
        end
        DONE: begin
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SNAKE_SELF_COLLIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      collide <= 1'b0;
    else if (frame_start)
      collide <= 1'b0;
    else if (state == PAINT && pos_valid(seg)
             && map[seg[9:5]][seg[4:0]])
      collide <= 1'b1;
  end
`else
  assign collide = 1'b0;
`endif

  // the map is single-buffered, so queries are blanked during a rebuild
  assign query_en = ready && !frame_start && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= 1'b0;
      is_head  <= 1'b0;
    end else begin
      occupied <= query_en && map[cell_row][cell_col];
      is_head  <= query_en && head_ok
               && ({cell_row, cell_col} == head);
    end
  end

endmodule

// File: tb/tb_snake_tile_painter.sv
// Randomised scoreboard bench for snake_tile_painter.
// Honours SNAKE_SELF_COLLIDE_EN when the same macro is set for the DUT.
module tb_snake_tile_painter;

`ifdef SNAKE_SELF_COLLIDE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic [3:0]   len;
  logic [159:0] pos_num;
  logic [9:0]   pix_x;
  logic [9:0]   pix_y;
  logic         busy;
  logic         ready;
  logic         occupied;
  logic         is_head;
  logic         collide;

  snake_tile_painter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .len         (len),
    .pos_num     (pos_num),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .busy        (busy),
    .ready       (ready),
    .occupied    (occupied),
    .is_head     (is_head),
    .collide     (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit occ;
    bit hd;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  bit m_ready = 1'b0;
  int m_len = 0;
  int m_pos[16];
  int s_len;
  int s_pos[16];

  function automatic int cell_of(int x, int y);
    return (y / 20) * 32 + (x / 20);
  endfunction

  function automatic bit m_occ(int x, int y);
    if (!m_ready || x >= 640 || y >= 480) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_pos[i] == cell_of(x, y)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hd(int x, int y);
    if (!m_ready || x >= 640 || y >= 480) return 1'b0;
    return (m_len > 0) && (m_pos[0] == cell_of(x, y));
  endfunction

  function automatic bit m_col();
    for (int i = 0; i < m_len; i++)
      for (int j = i + 1; j < m_len; j++)
        if (m_pos[i] < 768 && m_pos[i] == m_pos[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.due != cyc || occupied !== e.occ || is_head !== e.hd) begin
        n_fail++;
        $display("FAIL query(%0d,%0d): occupied=%b is_head=%b expected %b/%b (cycle %0d due %0d)",
                 e.x, e.y, occupied, is_head, e.occ, e.hd, cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic query(int x, int y);
    exp_t e;
    pix_x = 10'(x);
    pix_y = 10'(y);
    e = '{due: cyc + 1, occ: m_occ(x, y), hd: m_hd(x, y), x: x, y: y};
    sb.push_back(e);
  endtask

  task automatic rand_query();
    int r, i, x, y;
    r = $urandom_range(0, 9);
    if (r < 5 && m_len > 0) begin
      i = $urandom_range(0, m_len - 1);
      x = (m_pos[i] % 32) * 20 + $urandom_range(0, 19);
      y = (m_pos[i] / 32) * 20 + $urandom_range(0, 19);
    end else if (r < 8) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
    end else begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
    end
    query(x, y);
  endtask

  task automatic gen_snap();
    int r;
    s_len = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)             s_pos[i] = 1023;
      else if (r == 1)        s_pos[i] = $urandom_range(768, 1023);
      else if (r == 2 && i > 0) s_pos[i] = s_pos[$urandom_range(0, i - 1)];
      else                    s_pos[i] = $urandom_range(0, 767);
    end
  endtask

  task automatic start_frame();
    len = 4'(s_len);
    for (int i = 0; i < 16; i++) pos_num[i*10 +: 10] = 10'(s_pos[i]);
    frame_start = 1'b1;
    m_ready = 1'b0;
    m_len = s_len;
    m_pos = s_pos;
    rand_query();
    step();
    frame_start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ready_after_start", int'(ready), 0);
    chk("collide_cleared", int'(collide), 0);
    rand_query();
  endtask

  task automatic wait_ready();
    int k;
    bit busy_ok;
    k = 0;
    busy_ok = 1'b1;
    while (ready !== 1'b1 && k < 100) begin
      step();
      k++;
      if (ready !== 1'b1) begin
        busy_ok &= (busy === 1'b1);
        rand_query();
      end
    end
    chk("ready_latency", k, 26 + m_len);
    chk("busy_held", int'(busy_ok), 1);
    chk("busy_done", int'(busy), 0);
    chk("collide", int'(collide), EN ? int'(m_col()) : 0);
    m_ready = (ready === 1'b1);
  endtask

  task automatic queries(int n);
    repeat (n) begin
      rand_query();
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    len = '0;
    pos_num = '1;
    pix_x = '0;
    pix_y = '0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_occupied", int'(occupied), 0);
    chk("reset_is_head", int'(is_head), 0);
    chk("reset_collide", int'(collide), 0);
    step();
    rst_n = 1'b1;
    queries(3);

    s_pos = '{default: 1023};
    s_pos[0] = 'h065; s_pos[1] = 'h064;
    s_pos[2] = 'h063; s_pos[3] = 'h062;
    s_len = 4;
    start_frame();
    wait_ready();
    query(100, 60);  step();
    query(40, 60);   step();
    query(660, 60);  step();
    query(100, 80);  step();
    query(100, 500); step();
    queries(10);

    s_pos[2] = 1023;
    s_len = 3;
    start_frame();
    wait_ready();
    query(60, 60);   step();
    query(80, 60);   step();
    query(100, 60);  step();
    query(639, 479); step();

    s_len = 0;
    start_frame();
    wait_ready();
    query(100, 60);  step();
    query(0, 0);     step();

    s_pos = '{default: 1023};
    s_pos[0] = 'h065; s_pos[1] = 'h064; s_pos[2] = 'h065;
    s_len = 3;
    start_frame();
    wait_ready();
    query(100, 60);  step();
    queries(4);

    gen_snap();
    start_frame();
    repeat (9) begin
      step();
      rand_query();
    end
    gen_snap();
    start_frame();
    wait_ready();
    queries(20);

    s_len = 15;
    for (int i = 0; i < 16; i++) s_pos[i] = $urandom_range(0, 767);
    start_frame();
    repeat (30) begin
      step();
      rand_query();
    end
    rst_n = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_ready", int'(ready), 0);
    chk("midreset_occupied", int'(occupied), 0);
    chk("midreset_is_head", int'(is_head), 0);
    chk("midreset_collide", int'(collide), 0);
    step();
    rst_n = 1'b1;
    queries(4);
    chk("postreset_ready", int'(ready), 0);

    repeat (25) begin
      gen_snap();
      start_frame();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) begin
          step();
          rand_query();
        end
        gen_snap();
        start_frame();
      end
      wait_ready();
      queries(30);
    end

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
